cmd_link_responder: RTL and testbench
=====================================

Name: cmd_link_responder

Overview:
Robot-side end of the Bluetooth command link. It receives 16-bit commands from the remote as two 8N1 UART bytes (high byte first) and presents them to the command processor with a ready flag. It also serializes the 8-bit response byte (0xA5 = positive ack) back to the remote. It sits between the MazeRunner top-level RX/TX pins and the command FSM.

Parameters:
BAUD_DIV, 2604, clk cycles per UART bit; 12-bit counter; legal range 16..4095.
TIMEOUT_BITS, 20, bit-times allowed between end of high byte and start of low byte; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
RX  in  1  serial in from the remote; asynchronous to clk
TX  out  1  serial out to the remote; idles high
cmd  out  16  last complete command {high byte, low byte}
cmd_rdy  out  1  level; high while cmd holds an unconsumed command
clr_cmd_rdy  in  1  one-cycle pulse from the consumer; clears cmd_rdy
send_resp  in  1  one-cycle request to transmit resp
resp  in  8  response byte; sampled only in the cycle send_resp is accepted
resp_sent  out  1  one-cycle pulse when the stop bit of the response completes
tx_busy  out  1  high from acceptance of send_resp through the end of the stop bit

Behaviour:
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, resp_sent=0, tx_busy=0. All FSMs go to IDLE/HIGH. Reset mid-frame aborts the frame immediately with no partial output.
- RX synchronizer: two flops preset to 1 on rst. All RX logic uses the synchronized value only.
- RX core states:
  - IDLE: a falling edge moves to START.
  - START: samples at BAUD_DIV/2. If the line is still 0, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: 8 bits sampled every BAUD_DIV, LSB first.
  - STOP: samples the stop bit. If it is 1, pulse rx_byte_vld for one cycle. If it is 0, it is a framing error: pulse frm_err and drop the byte. Either way return to IDLE.
- Byte assembly FSM:
  - HIGH: on rx_byte_vld, latch high_byte and go to LOW.
  - LOW: on rx_byte_vld, cmd <= {high_byte, byte}; cmd_rdy=1 in the following cycle; return to HIGH.
  - frm_err in either state returns the FSM to HIGH and discards high_byte.
  - Latency: cmd_rdy rises 1 clk after the low byte's stop-bit sample.
- cmd_rdy rules:
  - It is cleared by clr_cmd_rdy.
  - It is also cleared when a new high byte is accepted (the stale command is withdrawn).
  - cmd stays stable while cmd_rdy=1.
  - If completion of a new command and clr_cmd_rdy occur in the same cycle, the set wins: cmd_rdy=1 with the new cmd.
- TX FSM:
  - IDLE: send_resp with tx_busy=0 loads the shift register {1, resp, 0} and sets tx_busy in the next cycle.
  - SHIFT: holds each of the 10 bits for BAUD_DIV cycles, LSB first after the start bit.
  - After the stop bit, pulse resp_sent for one cycle, clear tx_busy in the same cycle, and return to IDLE.
  - send_resp while tx_busy=1 is ignored; it is not queued.
  - send_resp in the same cycle as resp_sent is also ignored.
- RX and TX are fully independent; full duplex is legal.

Optional Feature:
Macro INTERBYTE_TIMEOUT_EN.
- Defined: in state LOW, a counter increments once per BAUD_DIV. After TIMEOUT_BITS bit-times with no start bit detected, the FSM returns to HIGH, discards high_byte, and leaves cmd_rdy unchanged. The counter resets on every entry to LOW.
- Not defined: LOW waits indefinitely; no counter logic is synthesized and TIMEOUT_BITS is unused.

Decomposition:
- Package cmd_link_pkg holds:
  - enums rx_state_t {IDLE, START, DATA, STOP}, asm_state_t {HIGH, LOW}, tx_state_t {IDLE, SHIFT}
  - localparams DATA_BITS=8, FRAME_BITS=10, ACK=8'hA5
- One sub-module, uart_rx_core (sync, RX FSM, rx_byte_vld/rx_byte/frm_err). Byte assembly and the TX FSM stay in the top.

Test Plan:
- Remote sends 0x23, 0xFF at BAUD_DIV=16 -> cmd=16'h23FF, cmd_rdy=1 one clk after the 2nd stop-bit sample. clr_cmd_rdy -> cmd_rdy=0 next cycle.
- Pulse send_resp with resp=0xA5 -> TX carries 0,1,0,1,0,0,1,0,1,1, each bit 16 clks wide; resp_sent pulses once; a second send_resp mid-frame produces no extra frame.
- High byte 0x40 sent with stop bit forced 0, then bytes 0x60, 0x00 -> cmd=16'h6000; the 0x40 is never seen.
- cmd_rdy=1 holding 0x4002, then a new high byte 0x60 -> cmd_rdy drops at acceptance; after 0x00 -> cmd=16'h6000.
- 1-clk low glitch on RX -> no byte, FSM stays HIGH. Assert rst mid-byte -> TX=1, cmd_rdy=0, and the next clean command 0x0000 is received correctly.
- With INTERBYTE_TIMEOUT_EN, send 0x23 then idle 21 bit-times, then 0x20, 0x00 -> cmd=16'h2000. Without the macro the same stimulus gives cmd=16'h2320.

Source files
------------

// File: rtl/cmd_link_pkg.sv
// Shared types and constants for the Bluetooth command link responder.
package cmd_link_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;

    localparam int         DATA_BITS  = 8;
    localparam int         FRAME_BITS = 10;
    localparam logic [7:0] ACK        = 8'hA5;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RX synchronizer, start-bit validation, LSB-first data and stop check.
// rx_active is exported only when INTERBYTE_TIMEOUT_EN is defined.
module uart_rx_core
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
`ifdef INTERBYTE_TIMEOUT_EN
    output logic       rx_active,
`endif
    output logic       rx_byte_vld,
    output logic [7:0] rx_byte,
    output logic       frm_err
);

    localparam logic [11:0] BIT_LAST  = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    rx_state_t   state_reg, state_next;
    logic [1:0]  sync_reg;
    logic        rx_prev_reg;
    logic [11:0] baud_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic        rx_s;
    logic        fall;
    logic        tick;

    assign rx_s    = sync_reg[1];
    // Falling edge needs a high history so a held-low line after a framing error is not a start bit.
    assign fall    = rx_prev_reg & ~rx_s;
    assign tick    = (state_reg == RX_START) ? (baud_cnt_reg == HALF_LAST)
                                             : (baud_cnt_reg == BIT_LAST);
    assign rx_byte = shift_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RX_IDLE;
            sync_reg     <= 2'b11;
            rx_prev_reg  <= 1'b1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            sync_reg    <= {sync_reg[0], rx};
            rx_prev_reg <= rx_s;
            if (state_reg == RX_IDLE || tick)
                baud_cnt_reg <= '0;
            else
                baud_cnt_reg <= baud_cnt_reg + 12'd1;
            if (state_reg == RX_START)
                bit_cnt_reg <= '0;
            else if (state_reg == RX_DATA && tick) begin
                shift_reg   <= {rx_s, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RX_IDLE:  if (fall) state_next = RX_START;
            RX_START: if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_cnt_reg == LAST_BIT) state_next = RX_STOP;
            RX_STOP:  if (tick) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_byte_vld = (state_reg == RX_STOP) && tick && rx_s;
        frm_err     = (state_reg == RX_STOP) && tick && !rx_s;
`ifdef INTERBYTE_TIMEOUT_EN
        rx_active   = (state_reg != RX_IDLE);
`endif
    end

endmodule

// File: rtl/cmd_link_responder.sv
// Robot-side command link: assembles 16-bit commands from two UART bytes and sends a response byte.
// Optional inter-byte timeout in LOW is enabled with INTERBYTE_TIMEOUT_EN.
module cmd_link_responder
    import cmd_link_pkg::*;
#(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        resp_sent,
    output logic        tx_busy
);

    localparam logic [11:0] BIT_LAST   = 12'(BAUD_DIV - 1);
    localparam logic [3:0]  LAST_FRAME = 4'(FRAME_BITS - 1);

    logic       rx_byte_vld;
    logic [7:0] rx_byte;
    logic       frm_err;
    logic       timeout;

`ifdef INTERBYTE_TIMEOUT_EN
    logic rx_active;
`endif

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (RX),
`ifdef INTERBYTE_TIMEOUT_EN
        .rx_active   (rx_active),
`endif
        .rx_byte_vld (rx_byte_vld),
        .rx_byte     (rx_byte),
        .frm_err     (frm_err)
    );

    // ---------------- byte assembly ----------------
    asm_state_t  asm_reg, asm_next;
    logic [7:0]  high_byte_reg;
    logic [15:0] cmd_reg;
    logic        cmd_rdy_reg;
    logic        accept_high;
    logic        accept_low;

    assign cmd     = cmd_reg;
    assign cmd_rdy = cmd_rdy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_reg       <= ASM_HIGH;
            high_byte_reg <= '0;
            cmd_reg       <= '0;
            cmd_rdy_reg   <= 1'b0;
        end else begin
            asm_reg <= asm_next;
            if (accept_high)
                high_byte_reg <= rx_byte;
            else if (frm_err || timeout)
                high_byte_reg <= '0;
            if (accept_low)
                cmd_reg <= {high_byte_reg, rx_byte};
            // Completion beats a simultaneous clear; a new high byte withdraws the stale command.
            if (accept_low)
                cmd_rdy_reg <= 1'b1;
            else if (accept_high || clr_cmd_rdy)
                cmd_rdy_reg <= 1'b0;
        end
    end

    always_comb begin
        asm_next = asm_reg;
        if (frm_err)
            asm_next = ASM_HIGH;
        else begin
            case (asm_reg)
                ASM_HIGH: if (rx_byte_vld) asm_next = ASM_LOW;
                ASM_LOW:  if (rx_byte_vld || timeout) asm_next = ASM_HIGH;
                default:  asm_next = ASM_HIGH;
            endcase
        end
    end

    always_comb begin
        accept_high = (asm_reg == ASM_HIGH) && rx_byte_vld;
        accept_low  = (asm_reg == ASM_LOW) && rx_byte_vld;
    end

`ifdef INTERBYTE_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_BITS);

    logic [11:0] to_div_reg;
    logic [15:0] to_bits_reg;
    logic        to_counting;

    // Bit-times are only counted while no low-byte frame is in progress.
    assign to_counting = (asm_reg == ASM_LOW) && !rx_active;
    assign timeout     = to_counting && (to_bits_reg == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || accept_high) begin
            to_div_reg  <= '0;
            to_bits_reg <= '0;
        end else if (to_counting) begin
            if (to_div_reg == BIT_LAST) begin
                to_div_reg  <= '0;
                to_bits_reg <= to_bits_reg + 16'd1;
            end else begin
                to_div_reg <= to_div_reg + 12'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // ---------------- response transmitter ----------------
    tx_state_t   tx_reg, tx_next;
    logic [9:0]  tx_shift_reg;
    logic [11:0] tx_cnt_reg;
    logic [3:0]  tx_bit_reg;
    logic        resp_sent_reg;
    logic        tx_accept;
    logic        tx_tick;
    logic        tx_done;

    // Idle shift content is all ones, so TX comes straight from a flop and idles high.
    assign TX        = tx_shift_reg[0];
    assign resp_sent = resp_sent_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg        <= TX_IDLE;
            tx_shift_reg  <= '1;
            tx_cnt_reg    <= '0;
            tx_bit_reg    <= '0;
            resp_sent_reg <= 1'b0;
        end else begin
            tx_reg        <= tx_next;
            resp_sent_reg <= tx_done;
            if (tx_accept) begin
                tx_shift_reg <= {1'b1, resp, 1'b0};
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= '0;
            end else if (tx_tick) begin
                tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
                tx_cnt_reg   <= '0;
                tx_bit_reg   <= tx_bit_reg + 4'd1;
            end else if (tx_reg == TX_SHIFT) begin
                tx_cnt_reg <= tx_cnt_reg + 12'd1;
            end
        end
    end

    always_comb begin
        tx_next = tx_reg;
        case (tx_reg)
            TX_IDLE:  if (tx_accept) tx_next = TX_SHIFT;
            TX_SHIFT: if (tx_done) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy   = (tx_reg == TX_SHIFT);
        tx_accept = (tx_reg == TX_IDLE) && send_resp && !resp_sent_reg;
        tx_tick   = (tx_reg == TX_SHIFT) && (tx_cnt_reg == BIT_LAST);
        tx_done   = tx_tick && (tx_bit_reg == LAST_FRAME);
    end

endmodule

// File: tb/tb_cmd_link_responder.sv
// Directed bench for cmd_link_responder at BAUD_DIV=16; expectations adapt to INTERBYTE_TIMEOUT_EN.
module tb_cmd_link_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RX = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        resp_sent;
    logic        tx_busy;

    int checks   = 0;
    int failures = 0;

    cmd_link_responder #(.BAUD_DIV(16), .TIMEOUT_BITS(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_sent   (resp_sent),
        .tx_busy     (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start bit and data; returns just after the stop bit level is applied.
    task automatic send_head(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        RX = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(16);
            RX = b[i];
        end
        tick(16);
        RX = stop;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_head(b, stop);
        tick(16);
        RX = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_tx;
        int         sent_cnt;
        exp_tx = 10'b1101001010;

        // reset state
        tick(3);
        check("rst_TX", TX, 1'b1);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_cmd_rdy", cmd_rdy, 1'b0);
        check("rst_resp_sent", resp_sent, 1'b0);
        check("rst_tx_busy", tx_busy, 1'b0);
        rst = 1'b0;
        tick(2);

        // 0x23, 0xFF with exact cmd_rdy latency
        send_byte(8'h23, 1'b1);
        send_head(8'hFF, 1'b1);
        tick(10);
        check("lat_before", cmd_rdy, 1'b0);
        tick(1);
        check("lat_rise", cmd_rdy, 1'b1);
        check("cmd_23ff", cmd, 16'h23FF);
        tick(5);
        RX = 1'b1;
        tick(4);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("clr_rdy", cmd_rdy, 1'b0);
        check("clr_cmd_hold", cmd, 16'h23FF);

        // response frame 0xA5, mid-frame and coincident requests ignored
        @(posedge clk);
        #1;
        send_resp = 1'b1;
        resp = 8'hA5;
        tick(1);
        send_resp = 1'b0;
        resp = 8'h00;
        check("tx_busy_start", tx_busy, 1'b1);
        sent_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 16 == 8 && c < 160)
                check($sformatf("tx_bit%0d", c / 16), TX, exp_tx[c / 16]);
            if (c == 160) begin
                check("resp_sent_pulse", resp_sent, 1'b1);
                check("tx_busy_end", tx_busy, 1'b0);
            end
            if (resp_sent)
                sent_cnt++;
            send_resp = (c == 50) || (c == 160);
            tick(1);
        end
        send_resp = 1'b0;
        check("resp_sent_count", sent_cnt, 1);
        check("tx_idle_after", TX, 1'b1);
        check("tx_busy_after", tx_busy, 1'b0);

        // framing error on high byte drops it
        send_byte(8'h40, 1'b0);
        send_byte(8'h60, 1'b1);
        check("ferr_cmd_hold", cmd, 16'h23FF);
        check("ferr_rdy_low", cmd_rdy, 1'b0);
        send_byte(8'h00, 1'b1);
        check("ferr_cmd", cmd, 16'h6000);
        check("ferr_rdy", cmd_rdy, 1'b1);

        // stale command withdrawn by new high byte; completion beats clear
        send_byte(8'h40, 1'b1);
        send_byte(8'h02, 1'b1);
        check("cmd_4002", cmd, 16'h4002);
        check("rdy_4002", cmd_rdy, 1'b1);
        send_byte(8'h60, 1'b1);
        check("withdraw_rdy", cmd_rdy, 1'b0);
        check("withdraw_cmd", cmd, 16'h4002);
        send_head(8'h00, 1'b1);
        tick(10);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        check("setwins_rdy", cmd_rdy, 1'b1);
        check("setwins_cmd", cmd, 16'h6000);
        tick(5);
        RX = 1'b1;

        // one-clock glitch: no byte
        tick(5);
        RX = 1'b0;
        tick(1);
        RX = 1'b1;
        tick(200);
        check("glitch_rdy", cmd_rdy, 1'b1);
        check("glitch_cmd", cmd, 16'h6000);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("cmd_1234", cmd, 16'h1234);

        // reset mid-byte with a response frame in flight
        @(posedge clk);
        #1;
        send_resp = 1'b1;
        resp = 8'h3C;
        tick(1);
        send_resp = 1'b0;
        RX = 1'b0;
        tick(16);
        RX = 1'b1;
        tick(16);
        RX = 1'b0;
        tick(5);
        check("pre_rst_busy", tx_busy, 1'b1);
        rst = 1'b1;
        RX = 1'b1;
        tick(1);
        check("mid_rst_TX", TX, 1'b1);
        check("mid_rst_rdy", cmd_rdy, 1'b0);
        check("mid_rst_busy", tx_busy, 1'b0);
        check("mid_rst_cmd", cmd, 16'h0000);
        rst = 1'b0;
        tick(20);
        check("post_rst_TX", TX, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("cmd_0000_rdy", cmd_rdy, 1'b1);
        check("cmd_0000", cmd, 16'h0000);

        // long gap between high and low byte
        send_byte(8'h23, 1'b1);
        tick(21 * 16);
        send_byte(8'h20, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef INTERBYTE_TIMEOUT_EN
        check("gap_cmd", cmd, 16'h2000);
        check("gap_rdy", cmd_rdy, 1'b1);
`else
        check("gap_cmd", cmd, 16'h2320);
        check("gap_rdy", cmd_rdy, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
